// File: rtl/proj_pkg.sv
// Shared types and constants for the fragment extension scheduler.
package proj_pkg;

    localparam int unsigned BASE_LEN = 2;
    localparam int unsigned NUM_REQ  = 2;
    localparam int unsigned SRC_W    = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    typedef logic [SRC_W-1:0]   src_t;
    typedef logic [NUM_REQ-1:0] req_vec_t;

    // Counter width that stays legal when a count collapses to one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/proj_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the loser after each grant.
module proj_rr_arb2
    import proj_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  req_vec_t req,
    input  logic     advance,
    output req_vec_t grant
);

    logic ptr_q;

    always_comb begin
        grant = '0;
        if (req[0] && req[1]) begin
            grant[ptr_q] = 1'b1;
        end else begin
            grant = req;
        end
    end

    // Granting requester 0 hands priority to 1 and vice versa.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (advance && (|grant)) begin
            ptr_q <= grant[0];
        end
    end

endmodule

// File: rtl/proj_extend_sched.sv
// Accepts fragment jobs from two requesters and streams one beat per
// fragment slice per k-mer index, with the start index extended and re-centred.
module proj_extend_sched
    import proj_pkg::*;
#(
    parameter int unsigned KMER_LEN          = 4,
    parameter int unsigned FRAG_LEN          = 8,
    parameter int unsigned FRAG_PART         = 2,
    parameter int unsigned INDICES_COUNT     = 3,
    parameter int unsigned INDICE_LEN        = 5,
    parameter int unsigned SIGNED_INDICE_LEN = INDICE_LEN + 1
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            flush,
    input  logic [NUM_REQ-1:0]                              req_valid,
    output logic [NUM_REQ-1:0]                              req_ready,
    input  logic [NUM_REQ-1:0][FRAG_LEN-1:0]                req_fragment,
    input  logic [NUM_REQ-1:0][INDICES_COUNT-1:0][INDICE_LEN-1:0] req_indices,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [SIGNED_INDICE_LEN-1:0]                    out_index,
    output logic [FRAG_PART-1:0]                            out_gfm,
    output src_t                                            out_src,
    output logic                                            out_last,
    output logic                                            busy
);

    localparam int unsigned FRAG_PARTS_COUNT = FRAG_LEN / FRAG_PART;
    localparam int unsigned PART_W           = cnt_width(FRAG_PARTS_COUNT);
    localparam int unsigned IDX_W            = cnt_width(INDICES_COUNT);
    localparam int unsigned EXT_OFFSET       = (FRAG_LEN - KMER_LEN) / BASE_LEN;

    state_e                                     state_q, state_d;
    logic [PART_W-1:0]                          part_q, part_d;
    logic [IDX_W-1:0]                           idx_q, idx_d;
    logic [FRAG_PARTS_COUNT-1:0][FRAG_PART-1:0] job_frag_q;
    logic [INDICES_COUNT-1:0][INDICE_LEN-1:0]   job_idx_q;
    src_t                                       job_src_q;

    req_vec_t grant;
    src_t     grant_id;
    logic     advance;
    logic     latch;
    logic     part_end;
    logic     idx_end;

    proj_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (advance),
        .grant   (grant)
    );

    assign grant_id = src_t'(grant[1]);
    assign part_end = (part_q == PART_W'(FRAG_PARTS_COUNT - 1));
    assign idx_end  = (idx_q == IDX_W'(INDICES_COUNT - 1));

    // Next-state, counter advance and grant handshake.
    always_comb begin
        state_d   = state_q;
        part_d    = part_q;
        idx_d     = idx_q;
        latch     = 1'b0;
        advance   = 1'b0;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (!flush && (|req_valid)) begin
                    req_ready = grant;
                    advance   = 1'b1;
                    latch     = 1'b1;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                if (flush) begin
                    state_d = IDLE;
                    part_d  = '0;
                    idx_d   = '0;
                end else if (out_ready) begin
                    if (part_end) begin
                        part_d = '0;
                        if (idx_end) begin
                            idx_d   = '0;
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        part_d = part_q + PART_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                part_d  = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            part_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            part_q  <= part_d;
            idx_q   <= idx_d;
        end
    end

    // Job payload captured from the winning requester at grant time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_frag_q <= '0;
            job_idx_q  <= '0;
            job_src_q  <= '0;
        end else if (latch) begin
            job_frag_q <= req_fragment[grant_id];
            job_idx_q  <= req_indices[grant_id];
            job_src_q  <= grant_id;
        end
    end

    // Beat fields decode directly from registered job state and counters.
    always_comb begin
        out_valid = (state_q == STREAM);
        busy      = (state_q != IDLE);
        out_src   = job_src_q;
        out_gfm   = job_frag_q[part_q];
        out_index = SIGNED_INDICE_LEN'({1'b0, job_idx_q[idx_q]})
                  - SIGNED_INDICE_LEN'(EXT_OFFSET);
        out_last  = (state_q == STREAM) && part_end && idx_end;
    end

endmodule

// File: tb/tb_proj_extend_sched.sv
// Directed bench for proj_extend_sched: single job, alternation, stalls, flush, async reset.
module tb_proj_extend_sched;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0][7:0]      req_fragment;
    logic [1:0][2:0][4:0] req_indices;
    logic                 out_valid;
    logic                 out_ready;
    logic [5:0]           out_index;
    logic [1:0]           out_gfm;
    logic                 out_src;
    logic                 out_last;
    logic                 busy;

    int passed = 0;
    int total  = 0;

    // Expected out_index for indices {3,7,20} and {0,1,31}.
    logic [5:0] exp_a [3] = '{6'd1, 6'd5, 6'd18};
    logic [5:0] exp_b [3] = '{6'h3E, 6'h3F, 6'h1D};

    always #5 clk = ~clk;

    proj_extend_sched dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_fragment (req_fragment),
        .req_indices  (req_indices),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_index    (out_index),
        .out_gfm      (out_gfm),
        .out_src      (out_src),
        .out_last     (out_last),
        .busy         (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        flush        = 1'b0;
        req_valid    = 2'b00;
        out_ready    = 1'b0;
        req_fragment = '0;
        req_indices  = '0;
        #3;
        total++;
        if ({out_valid, req_ready, busy, out_src, out_last} !== 6'b0) begin
            $display("FAIL reset_outputs: got %b expected 000000",
                     {out_valid, req_ready, busy, out_src, out_last});
        end else passed++;
        total++;
        if ({out_gfm, out_index} !== {2'b00, 6'h3E}) begin
            $display("FAIL reset_beat_fields: got %h expected %h", {out_gfm, out_index}, {2'b00, 6'h3E});
        end else passed++;
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++;
        if ({out_valid, busy} !== 2'b00) begin
            $display("FAIL reset_release_idle: got %b expected 00", {out_valid, busy});
        end else passed++;
    endtask

    task automatic test_single();
        req_fragment[0] = 8'b11_10_01_00;
        req_indices[0]  = {5'd20, 5'd7, 5'd3};
        req_valid       = 2'b01;
        out_ready       = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            $display("FAIL single_grant: got %b expected 01", req_ready);
        end else passed++;
        tick();
        req_valid = 2'b00;
        for (int b = 0; b < 12; b++) begin
            total++;
            if ({out_valid, out_src, out_gfm, out_index, out_last} !==
                {1'b1, 1'b0, 2'(b % 4), exp_a[b / 4], (b == 11)}) begin
                $display("FAIL single_beat%0d: got v%b s%b g%0d i%h l%b expected g%0d i%h l%b",
                         b, out_valid, out_src, out_gfm, out_index, out_last,
                         b % 4, exp_a[b / 4], (b == 11));
            end else passed++;
            tick();
        end
        total++;
        if ({busy, out_valid} !== 2'b00) begin
            $display("FAIL single_done_idle: got %b expected 00", {busy, out_valid});
        end else passed++;
    endtask

    task automatic test_alternate();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_fragment[0] = 8'b11_10_01_00;
        req_indices[0]  = {5'd20, 5'd7, 5'd3};
        req_fragment[1] = 8'b00_01_10_11;
        req_indices[1]  = {5'd31, 5'd1, 5'd0};
        req_valid       = 2'b11;
        out_ready       = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            automatic logic s = 1'(j % 2);
            total++;
            if (req_ready !== (s ? 2'b10 : 2'b01)) begin
                $display("FAIL alt_grant%0d: got %b expected %b", j, req_ready, (s ? 2'b10 : 2'b01));
            end else passed++;
            tick();
            total++;
            if (req_ready !== 2'b00) begin
                $display("FAIL alt_ready_in_stream%0d: got %b expected 00", j, req_ready);
            end else passed++;
            for (int b = 0; b < 12; b++) begin
                automatic logic [1:0] eg = s ? 2'(3 - (b % 4)) : 2'(b % 4);
                automatic logic [5:0] ei = s ? exp_b[b / 4] : exp_a[b / 4];
                total++;
                if ({out_valid, out_src, out_gfm, out_index, out_last} !==
                    {1'b1, s, eg, ei, (b == 11)}) begin
                    $display("FAIL alt_job%0d_beat%0d: got v%b s%b g%0d i%h l%b expected s%b g%0d i%h",
                             j, b, out_valid, out_src, out_gfm, out_index, out_last, s, eg, ei);
                end else passed++;
                tick();
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_stall();
        int b = 0;
        int cyc = 0;
        logic hs;
        req_fragment[0] = 8'b11_10_01_00;
        req_indices[0]  = {5'd20, 5'd7, 5'd3};
        req_valid       = 2'b01;
        out_ready       = 1'b0;
        tick();
        req_valid = 2'b00;
        while (b < 12 && cyc < 300) begin
            total++;
            if ({out_valid, out_src, out_gfm, out_index, out_last} !==
                {1'b1, 1'b0, 2'(b % 4), exp_a[b / 4], (b == 11)}) begin
                $display("FAIL stall_cyc%0d_beat%0d: got v%b g%0d i%h l%b expected g%0d i%h l%b",
                         cyc, b, out_valid, out_gfm, out_index, out_last, b % 4, exp_a[b / 4], (b == 11));
            end else passed++;
            hs = (cyc < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            out_ready = hs;
            tick();
            if (hs) b++;
            cyc++;
        end
        total++;
        if (b != 12 || busy !== 1'b0) begin
            $display("FAIL stall_complete: got beats %0d busy %b expected 12 0", b, busy);
        end else passed++;
        out_ready = 1'b1;
    endtask

    task automatic test_flush();
        req_fragment[0] = 8'b11_10_01_00;
        req_indices[0]  = {5'd20, 5'd7, 5'd3};
        req_valid       = 2'b01;
        out_ready       = 1'b1;
        tick();
        req_valid = 2'b00;
        for (int b = 0; b < 4; b++) tick();
        total++;
        if ({out_valid, out_gfm, out_index} !== {1'b1, 2'd0, 6'd5}) begin
            $display("FAIL flush_beat5: got v%b g%0d i%h expected v1 g0 i05", out_valid, out_gfm, out_index);
        end else passed++;
        flush     = 1'b1;
        req_valid = 2'b01;
        tick();
        total++;
        if ({busy, out_valid, req_ready} !== 4'b0) begin
            $display("FAIL flush_idle_no_grant: got %b expected 0000", {busy, out_valid, req_ready});
        end else passed++;
        flush = 1'b0;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            $display("FAIL flush_regrant: got %b expected 01", req_ready);
        end else passed++;
        tick();
        req_valid = 2'b00;
        total++;
        if ({out_valid, out_gfm, out_index, out_last} !== {1'b1, 2'd0, 6'd1, 1'b0}) begin
            $display("FAIL flush_next_job_start: got v%b g%0d i%h l%b expected v1 g0 i01 l0",
                     out_valid, out_gfm, out_index, out_last);
        end else passed++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            $display("FAIL flush_cleanup: got busy %b expected 0", busy);
        end else passed++;
    endtask

    task automatic test_async_reset();
        req_fragment[1] = 8'b00_01_10_11;
        req_indices[1]  = {5'd31, 5'd1, 5'd0};
        req_valid       = 2'b11;
        out_ready       = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b10) begin
            $display("FAIL arst_pre_grant: got %b expected 10", req_ready);
        end else passed++;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        total++;
        if ({out_valid, out_src, busy} !== 3'b111) begin
            $display("FAIL arst_mid_stream: got %b expected 111", {out_valid, out_src, busy});
        end else passed++;
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, busy, req_ready, out_src, out_last, out_gfm, out_index} !==
            {6'b0, 2'b00, 6'h3E}) begin
            $display("FAIL arst_immediate: got v%b b%b r%b s%b l%b g%0d i%h expected all zero i3e",
                     out_valid, busy, req_ready, out_src, out_last, out_gfm, out_index);
        end else passed++;
        tick();
        rst = 1'b0;
        tick();
        tick();
        total++;
        if ({out_valid, busy} !== 2'b00) begin
            $display("FAIL arst_no_stale_beat: got %b expected 00", {out_valid, busy});
        end else passed++;
        req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            $display("FAIL arst_priority: got %b expected 01", req_ready);
        end else passed++;
        tick();
        req_valid = 2'b00;
        total++;
        if ({out_valid, out_src, out_gfm, out_index} !== {1'b1, 1'b0, 2'd0, 6'd1}) begin
            $display("FAIL arst_new_job: got v%b s%b g%0d i%h expected v1 s0 g0 i01",
                     out_valid, out_src, out_gfm, out_index);
        end else passed++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_stall();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
